// File: rtl/ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_stage : execute stage - ALU, {Z,V,N} flag register, branch resolve,   |
// |            EX/MEM pipeline register. Build macro: SAT_ARITH_EN (ADD/SUB  |
// |            saturate instead of wrapping).          Revision: 1.0         |
// +--------------------------------------------------------------------------+
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we,
  input  logic [15:0] reg_rd_1_i,
  input  logic [15:0] reg_rd_2_i,
  input  logic [15:0] pc_i,
  input  logic [15:0] imm_i,
  input  logic [8:0]  br_off_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  op_i,
  input  logic [2:0]  ccode_i,
  output logic [15:0] alu_o,
  output logic [15:0] st_data_o,
  output logic [15:0] pc_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  op_o,
  output logic [2:0]  flags_o,
  output logic        branch_o,
  output logic [15:0] br_tgt_o
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
                         OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
                         OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
                         OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE;

  logic [15:0] alu_d, alu_q, st_data_d, st_data_q, pc_d, pc_q;
  logic [3:0]  rd_d, rd_q, op_d, op_q;
  logic [2:0]  flags_d, flags_q;

  logic [15:0] a, b;
  logic [3:0]  sh;
  assign a  = reg_rd_1_i;
  assign b  = reg_rd_2_i;
  assign sh = imm_i[3:0];

  logic [15:0] add_sum, sub_diff, add_res, sub_res;
  logic        add_ovf, sub_ovf;
  assign add_sum  = a + b;
  assign sub_diff = a - b;
  assign add_ovf  = (a[15] == b[15]) && (add_sum[15] != a[15]);
  assign sub_ovf  = (a[15] != b[15]) && (sub_diff[15] != a[15]);

`ifdef SAT_ARITH_EN
  // On overflow the true result lies beyond the limit on A's side of zero.
  assign add_res = add_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : add_sum;
  assign sub_res = sub_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : sub_diff;
`else
  assign add_res = add_sum;
  assign sub_res = sub_diff;
`endif

  logic [9:0] red_sum;
  assign red_sum = {{2{a[15]}}, a[15:8]} + {{2{b[15]}}, b[15:8]}
                 + {{2{a[7]}},  a[7:0]}  + {{2{b[7]}},  b[7:0]};

  logic [15:0] paddsb_res;
  generate
    for (genvar i = 0; i < 4; i++) begin : g_nib
      logic [3:0] s;
      logic       ov;
      assign s  = a[4*i+3:4*i] + b[4*i+3:4*i];
      assign ov = (a[4*i+3] == b[4*i+3]) && (s[3] != a[4*i+3]);
      assign paddsb_res[4*i+3:4*i] = ov ? (a[4*i+3] ? 4'h8 : 4'h7) : s;
    end
  endgenerate

  logic [15:0] alu_res;
  logic        set_z, set_vn, ovf;
  always_comb begin
    alu_res = 16'h0000;
    set_z   = 1'b0;
    set_vn  = 1'b0;
    ovf     = 1'b0;
    case (op_i)
      OP_ADD:    begin alu_res = add_res; set_z = 1'b1; set_vn = 1'b1; ovf = add_ovf; end
      OP_SUB:    begin alu_res = sub_res; set_z = 1'b1; set_vn = 1'b1; ovf = sub_ovf; end
      OP_XOR:    begin alu_res = a ^ b; set_z = 1'b1; end
      OP_RED:    alu_res = {{6{red_sum[9]}}, red_sum};
      OP_SLL:    begin alu_res = a << sh; set_z = 1'b1; end
      OP_SRA:    begin alu_res = 16'($signed(a) >>> sh); set_z = 1'b1; end
      // A shift of 16 yields zero, so an amount of 0 leaves A untouched.
      OP_ROR:    begin alu_res = (a >> sh) | (a << (5'd16 - {1'b0, sh})); set_z = 1'b1; end
      OP_PADDSB: alu_res = paddsb_res;
      OP_LW,
      OP_SW:     alu_res = (a & 16'hFFFE) + imm_i;
      OP_LHB:    alu_res = (a & 16'h00FF) | {imm_i[7:0], 8'h00};
      OP_LLB:    alu_res = (a & 16'hFF00) | {8'h00, imm_i[7:0]};
      OP_PCS:    alu_res = pc_i;
      default:   alu_res = 16'h0000;
    endcase
  end

  always_comb begin
    alu_d     = alu_q;
    st_data_d = st_data_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    op_d      = op_q;
    flags_d   = flags_q;
    if (ex_we) begin
      alu_d     = alu_res;
      st_data_d = b;
      pc_d      = pc_i;
      rd_d      = rd_i;
      op_d      = op_i;
      if (set_z)  flags_d[2]   = (alu_res == 16'h0000);
      if (set_vn) flags_d[1:0] = {ovf, alu_res[15]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q     <= 16'h0000;
      st_data_q <= 16'h0000;
      pc_q      <= 16'h0000;
      rd_q      <= 4'h0;
      op_q      <= 4'h0;
      flags_q   <= 3'b000;
    end else begin
      alu_q     <= alu_d;
      st_data_q <= st_data_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
    end
  end

  logic flag_z, flag_v, flag_n, cond_true;
  assign {flag_z, flag_v, flag_n} = flags_q;
  always_comb begin
    cond_true = 1'b0;
    case (ccode_i)
      3'b000: cond_true = ~flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = ~flag_z & ~flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z | ~flag_n;
      3'b101: cond_true = flag_n | flag_z;
      3'b110: cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign branch_o = ((op_i == OP_B) || (op_i == OP_BR)) && cond_true && ex_we;
  assign br_tgt_o = (op_i == OP_B)  ? pc_i + {{6{br_off_i[8]}}, br_off_i, 1'b0} :
                    (op_i == OP_BR) ? reg_rd_1_i : 16'h0000;

  assign alu_o     = alu_q;
  assign st_data_o = st_data_q;
  assign pc_o      = pc_q;
  assign rd_o      = rd_q;
  assign op_o      = op_q;
  assign flags_o   = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_stage : directed table-driven bench for ex_stage.                  |
// |                                                    Revision: 1.0         |
// +--------------------------------------------------------------------------+
module tb_ex_stage;

  logic        clk, rst, ex_we;
  logic [15:0] reg_rd_1_i, reg_rd_2_i, pc_i, imm_i;
  logic [8:0]  br_off_i;
  logic [3:0]  rd_i, op_i;
  logic [2:0]  ccode_i;
  logic [15:0] alu_o, st_data_o, pc_o, br_tgt_o;
  logic [3:0]  rd_o, op_o;
  logic [2:0]  flags_o;
  logic        branch_o;

  ex_stage dut (
    .clk(clk), .rst(rst), .ex_we(ex_we),
    .reg_rd_1_i(reg_rd_1_i), .reg_rd_2_i(reg_rd_2_i), .pc_i(pc_i), .imm_i(imm_i),
    .br_off_i(br_off_i), .rd_i(rd_i), .op_i(op_i), .ccode_i(ccode_i),
    .alu_o(alu_o), .st_data_o(st_data_o), .pc_o(pc_o), .rd_o(rd_o), .op_o(op_o),
    .flags_o(flags_o), .branch_o(branch_o), .br_tgt_o(br_tgt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SAT_ARITH_EN
  localparam logic [15:0] ADD_OVF_RES = 16'h7FFF;
  localparam logic [2:0]  ADD_OVF_FL  = 3'b010;
  localparam logic [15:0] SUB_OVF_RES = 16'h8000;
  localparam logic [2:0]  SUB_OVF_FL  = 3'b011;
`else
  localparam logic [15:0] ADD_OVF_RES = 16'h8000;
  localparam logic [2:0]  ADD_OVF_FL  = 3'b011;
  localparam logic [15:0] SUB_OVF_RES = 16'h7FFF;
  localparam logic [2:0]  SUB_OVF_FL  = 3'b010;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, imm, pc;
    logic [15:0] exp_alu;
    logic [2:0]  exp_flags;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic [15:0] pc,
                       input logic [3:0] rd, input logic [2:0] cc, input logic [8:0] off);
    ex_we = we; op_i = op; reg_rd_1_i = a; reg_rd_2_i = b; imm_i = imm;
    pc_i = pc; rd_i = rd; ccode_i = cc; br_off_i = off;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [15:0] alu, input logic [15:0] st,
                            input logic [15:0] pc, input logic [3:0] rd, input logic [3:0] op,
                            input logic [2:0] fl);
    check({tag, ".alu"},   32'(alu_o),     32'(alu));
    check({tag, ".st"},    32'(st_data_o), 32'(st));
    check({tag, ".pc"},    32'(pc_o),      32'(pc));
    check({tag, ".rd"},    32'(rd_o),      32'(rd));
    check({tag, ".op"},    32'(op_o),      32'(op));
    check({tag, ".flags"}, 32'(flags_o),   32'(fl));
  endtask

  logic [7:0] exp_cond;

  initial begin
    //           op    A        B        imm      pc       exp_alu      flags {Z,V,N}
    vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h0000, 16'h0100, ADD_OVF_RES, ADD_OVF_FL};
    vecs[1]  = '{4'h7, 16'h7181, 16'h1178, 16'h0000, 16'h0102, 16'h72F9,    ADD_OVF_FL};
    vecs[2]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0104, 16'h0000,    3'b100};
    vecs[3]  = '{4'h3, 16'h7F80, 16'h7F80, 16'h0000, 16'h0106, 16'hFFFE,    3'b100};
    vecs[4]  = '{4'h4, 16'h8001, 16'h0000, 16'h0001, 16'h0108, 16'h0002,    3'b000};
    vecs[5]  = '{4'h5, 16'h8000, 16'h0000, 16'h0004, 16'h010A, 16'hF800,    3'b000};
    vecs[6]  = '{4'h6, 16'h1234, 16'h0000, 16'h0004, 16'h010C, 16'h4123,    3'b000};
    vecs[7]  = '{4'h6, 16'h1234, 16'h0000, 16'h0000, 16'h010E, 16'h1234,    3'b000};
    vecs[8]  = '{4'h4, 16'h0000, 16'h0000, 16'h0003, 16'h0110, 16'h0000,    3'b100};
    vecs[9]  = '{4'h8, 16'h1003, 16'h5555, 16'hFFFE, 16'h0112, 16'h1000,    3'b100};
    vecs[10] = '{4'hA, 16'h1234, 16'h0000, 16'h00AB, 16'h0114, 16'hAB34,    3'b100};
    vecs[11] = '{4'hB, 16'h1234, 16'h0000, 16'h00CD, 16'h0116, 16'h12CD,    3'b100};
    vecs[12] = '{4'hE, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h4000,    3'b100};
    vecs[13] = '{4'h1, 16'h8000, 16'h0001, 16'h0000, 16'h011A, SUB_OVF_RES, SUB_OVF_FL};
    vecs[14] = '{4'h0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h011C, 16'hFFFE,    3'b001};
    vecs[15] = '{4'hF, 16'h1111, 16'h2222, 16'h0000, 16'h011E, 16'h0000,    3'b001};
    vecs[16] = '{4'h9, 16'h2001, 16'hBEEF, 16'h0004, 16'h0120, 16'h2004,    3'b001};

    rst = 1'b1;
    drive(1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 3'b000, 9'h0);
    #2;
    check_regs("reset", 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 3'b000);
    check("reset.branch", 32'(branch_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, 4'(i), 3'b111, 9'h0);
      tick();
      check_regs($sformatf("vec%0d", i), vecs[i].exp_alu, vecs[i].b, vecs[i].pc,
                 4'(i), vecs[i].op, vecs[i].exp_flags);
      check($sformatf("vec%0d.branch", i), 32'(branch_o), 32'd0);
    end

    // Stall: three cycles of changing inputs, including a taken-looking branch.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b0, 4'hC, 16'h1357 + 16'(c), 16'h2468, 16'h000F, 16'h3000, 4'h7, 3'b111, 9'h005);
      #1;
      check($sformatf("stall%0d.branch", c), 32'(branch_o), 32'd0);
      tick();
      check_regs($sformatf("stall%0d", c), 16'h2004, 16'hBEEF, 16'h0120, 4'h0, 4'h9, 3'b001);
    end

    // SUB 5-5 sets Z; then sweep every condition code against flags {1,0,0}.
    @(negedge clk);
    drive(1'b1, 4'h1, 16'h0005, 16'h0005, 16'h0, 16'h0200, 4'h3, 3'b000, 9'h0);
    tick();
    check("sub_z.flags", 32'(flags_o), 32'b100);
    @(negedge clk);
    drive(1'b1, 4'hC, 16'h0, 16'h0, 16'h0, 16'h0010, 4'h0, 3'b001, 9'h1FE);
    #1;
    check("b_eq.branch", 32'(branch_o), 32'd1);
    check("b_eq.tgt",    32'(br_tgt_o), 32'h000C);
    exp_cond = 8'b1011_0010;
    for (int cc = 0; cc < 8; cc++) begin
      ccode_i = 3'(cc);
      #1;
      check($sformatf("cond%0d.branch", cc), 32'(branch_o), 32'(exp_cond[cc]));
    end
    ccode_i = 3'b111;
    ex_we = 1'b0;
    #1;
    check("b_nowe.branch", 32'(branch_o), 32'd0);
    ex_we = 1'b1;
    pc_i = 16'h0002; br_off_i = 9'h0FF;
    #1;
    check("b_fwd.tgt", 32'(br_tgt_o), 32'h0200);
    br_off_i = 9'h100;
    #1;
    check("b_wrap.tgt", 32'(br_tgt_o), 32'hFE02);
    op_i = 4'hD; reg_rd_1_i = 16'h3456;
    #1;
    check("br.branch", 32'(branch_o), 32'd1);
    check("br.tgt",    32'(br_tgt_o), 32'h3456);
    op_i = 4'h0;
    #1;
    check("add.tgt", 32'(br_tgt_o), 32'h0000);
    op_i = 4'hC;
    tick();
    check_regs("b_clk", 16'h0000, 16'h0000, 16'h0002, 4'h0, 4'hC, 3'b100);

    // Overflow flag feeds the V condition on the following cycle.
    @(negedge clk);
    drive(1'b1, 4'h0, 16'h7FFF, 16'h0001, 16'h0, 16'h0300, 4'h5, 3'b000, 9'h0);
    tick();
    check("ovf.flags", 32'(flags_o), 32'(ADD_OVF_FL));
    @(negedge clk);
    drive(1'b1, 4'hC, 16'h0, 16'h0, 16'h0, 16'h0300, 4'h0, 3'b110, 9'h002);
    #1;
    check("bv.branch", 32'(branch_o), 32'd1);
    check("bv.tgt",    32'(br_tgt_o), 32'h0304);

    // Asynchronous reset between edges right after an ADD loads.
    @(negedge clk);
    drive(1'b1, 4'h0, 16'h0100, 16'h0023, 16'h0, 16'h0400, 4'h9, 3'b000, 9'h0);
    tick();
    check("pre_rst.alu", 32'(alu_o), 32'h0123);
    #1 rst = 1'b1;
    #1;
    check_regs("async_rst", 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'h2, 16'h00FF, 16'h0F0F, 16'h0, 16'h0500, 4'h6, 3'b000, 9'h0);
    tick();
    check_regs("post_rst", 16'h0FF0, 16'h0F0F, 16'h0500, 4'h6, 4'h2, 3'b000);

    // Reset while stalled discards the held state.
    @(negedge clk);
    ex_we = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    check_regs("stall_rst", 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
